// File: rtl/serial_txn_pkg.sv
// rtl/serial_txn_pkg.sv - shared op encoding, header bytes, FSM states and gap length
package serial_txn_pkg;

    typedef enum logic [1:0] {
        OP_ILLEGAL = 2'd0,
        OP_CONFIG  = 2'd1,
        OP_START   = 2'd2,
        OP_READ    = 2'd3
    } op_e;

    localparam logic [7:0] HDR_CONFIG = 8'h0F;
    localparam logic [7:0] HDR_START  = 8'h33;
    localparam logic [7:0] HDR_READ   = 8'hC3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_CFG,
        ST_TURN,
        ST_RD,
        ST_GAP
    } state_e;

    // Low cycles between the end of one frame and the start of the next.
    localparam int GAP_LEN = 2;

    function automatic logic [7:0] hdr_byte(input op_e op);
        case (op)
            OP_CONFIG: hdr_byte = HDR_CONFIG;
            OP_START:  hdr_byte = HDR_START;
            OP_READ:   hdr_byte = HDR_READ;
            default:   hdr_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/serial_txn_sched_if.sv
// rtl/serial_txn_sched_if.sv - requester handshake and serial pad bundle
// Ports: req/op/wdata request side, ack/done/err/rdata/busy responses,
//        frame/ser_o/ser_oe/ser_i serial pad, suspend slave stall.
interface serial_txn_sched_if;

    logic [1:0]  req;
    logic [3:0]  op;
    logic [15:0] wdata;
    logic [1:0]  ack;
    logic [1:0]  done;
    logic [1:0]  err;
    logic [7:0]  rdata;
    logic        busy;
    logic        frame;
    logic        ser_o;
    logic        ser_oe;
    logic        ser_i;
    logic        suspend;

    modport master (
        output req, op, wdata, ser_i, suspend,
        input  ack, done, err, rdata, busy, frame, ser_o, ser_oe
    );

    modport slave (
        input  req, op, wdata, ser_i, suspend,
        output ack, done, err, rdata, busy, frame, ser_o, ser_oe
    );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter
// Ports: clk, rst (async, active-high), req[1:0] requests, advance (grant
//        consumed), grant[1:0] one-hot grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // ptr names the requester that wins a tie.
    logic ptr;

    always_comb begin
        grant = 2'b00;
        if (req[0] && (!req[1] || !ptr)) begin
            grant = 2'b01;
        end else if (req[1]) begin
            grant = 2'b10;
        end
    end

    // The requester just served loses the next tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (advance && (|grant)) begin
            ptr <= grant[0];
        end
    end

endmodule

// File: rtl/serial_txn_sched.sv
// rtl/serial_txn_sched.sv - two-requester serial transaction scheduler
// Ports: clk, rst (async, active-high), bus (serial_txn_sched_if.slave):
//        requests in, registered ack/done/err/rdata/busy out, serial pad.
module serial_txn_sched
    import serial_txn_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    serial_txn_sched_if.slave bus
);

    state_e     state;
    logic [2:0] bit_cnt;
    logic [1:0] gap_cnt;
    logic       launch_q;
    op_e        op_q;
    logic [7:0] hdr_q;
    logic [7:0] wdata_q;
    logic [6:0] rd_shift;
    logic       gnt_id;

    logic [1:0] ack_q;
    logic [1:0] done_q;
    logic [1:0] err_q;
    logic [7:0] rdata_q;
    logic       busy_q;
    logic       frame_q;
    logic       ser_o_q;
    logic       ser_oe_q;

    logic [1:0] grant;
    logic       accept_win;
    logic       take;
    logic       frame_end;
    logic [2:0] next_bit;
    op_e        sel_op;
    logic [7:0] sel_wdata;

    // A new request may be accepted in idle, or in the first gap cycle so
    // that the next frame starts right as the gap ends.
    assign accept_win = (state == ST_IDLE && !launch_q) ||
                        (state == ST_GAP && gap_cnt == 2'(GAP_LEN - 2));
    assign take       = accept_win && !bus.suspend && (|bus.req);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req),
        .advance (take),
        .grant   (grant)
    );

    assign sel_op    = op_e'(grant[1] ? bus.op[3:2] : bus.op[1:0]);
    assign sel_wdata = grant[1] ? bus.wdata[15:8] : bus.wdata[7:0];
    assign next_bit  = bit_cnt + 3'd1;

    // Last active bit of the frame: start ends after its header, config
    // after the data byte, read after the sampled byte.
    assign frame_end = !bus.suspend && (bit_cnt == 3'd7) &&
                       ((state == ST_HDR && op_q != OP_CONFIG && op_q != OP_READ) ||
                        state == ST_CFG || state == ST_RD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            bit_cnt  <= 3'd0;
            gap_cnt  <= 2'd0;
            launch_q <= 1'b0;
            op_q     <= OP_ILLEGAL;
            hdr_q    <= 8'h00;
            wdata_q  <= 8'h00;
            rd_shift <= 7'h00;
            gnt_id   <= 1'b0;
            ack_q    <= 2'b00;
            done_q   <= 2'b00;
            err_q    <= 2'b00;
            rdata_q  <= 8'h00;
            busy_q   <= 1'b0;
            frame_q  <= 1'b0;
            ser_o_q  <= 1'b0;
            ser_oe_q <= 1'b0;
        end else begin
            ack_q  <= 2'b00;
            done_q <= 2'b00;
            err_q  <= 2'b00;

            if (take) begin
                ack_q   <= grant;
                gnt_id  <= grant[1];
                op_q    <= sel_op;
                hdr_q   <= hdr_byte(sel_op);
                wdata_q <= sel_wdata;
                if (sel_op == OP_ILLEGAL) begin
                    err_q <= grant;
                end else begin
                    launch_q <= 1'b1;
                    busy_q   <= 1'b1;
                end
            end

            if (frame_end) begin
                frame_q  <= 1'b0;
                ser_oe_q <= 1'b0;
                ser_o_q  <= 1'b0;
                done_q   <= gnt_id ? 2'b10 : 2'b01;
                gap_cnt  <= 2'd0;
                state    <= ST_GAP;
                if (state == ST_RD) begin
                    rdata_q <= {bus.ser_i, rd_shift};
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (launch_q) begin
                            launch_q <= 1'b0;
                            frame_q  <= 1'b1;
                            ser_oe_q <= 1'b1;
                            ser_o_q  <= hdr_q[0];
                            bit_cnt  <= 3'd0;
                            state    <= ST_HDR;
                        end
                    end
                    ST_HDR: begin
                        if (!bus.suspend) begin
                            if (bit_cnt == 3'd7) begin
                                bit_cnt <= 3'd0;
                                if (op_q == OP_CONFIG) begin
                                    ser_o_q <= wdata_q[0];
                                    state   <= ST_CFG;
                                end else begin
                                    ser_oe_q <= 1'b0;
                                    ser_o_q  <= 1'b0;
                                    state    <= ST_TURN;
                                end
                            end else begin
                                bit_cnt <= next_bit;
                                ser_o_q <= hdr_q[next_bit];
                            end
                        end
                    end
                    ST_CFG: begin
                        if (!bus.suspend) begin
                            bit_cnt <= next_bit;
                            ser_o_q <= wdata_q[next_bit];
                        end
                    end
                    ST_TURN: begin
                        if (!bus.suspend) begin
                            bit_cnt <= 3'd0;
                            state   <= ST_RD;
                        end
                    end
                    ST_RD: begin
                        if (!bus.suspend) begin
                            rd_shift[bit_cnt] <= bus.ser_i;
                            bit_cnt           <= next_bit;
                        end
                    end
                    ST_GAP: begin
                        // The gap runs on plain clocks; suspend does not stretch it.
                        if (gap_cnt == 2'(GAP_LEN - 1)) begin
                            if (launch_q) begin
                                launch_q <= 1'b0;
                                frame_q  <= 1'b1;
                                ser_oe_q <= 1'b1;
                                ser_o_q  <= hdr_q[0];
                                bit_cnt  <= 3'd0;
                                state    <= ST_HDR;
                            end else begin
                                busy_q <= 1'b0;
                                state  <= ST_IDLE;
                            end
                        end else begin
                            gap_cnt <= gap_cnt + 2'd1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.ack    = ack_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.rdata  = rdata_q;
    assign bus.busy   = busy_q;
    assign bus.frame  = frame_q;
    assign bus.ser_o  = ser_o_q;
    assign bus.ser_oe = ser_oe_q;

endmodule
